// File: rtl/instruction_fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage_pkg
// Constants shared by the fetch stage and the hazard unit:
//   - addrSel encodings (sequential / jump / branch)
//   - the NOP pattern loaded into IF/ID on a flush or bubble
//   - the fetch FSM state encoding (REQ: request outstanding, BUF: response held)
//   - a helper that decides whether the next-PC select is a taken redirect
// ----------------------------------------------------------------------------
package instruction_fetch_stage_pkg;

  localparam logic [1:0] ADDR_SEQ    = 2'b00;
  localparam logic [1:0] ADDR_JUMP   = 2'b01;
  localparam logic [1:0] ADDR_BRANCH = 2'b10;

  localparam int unsigned NOP_INSTR = 0;

  typedef enum logic {
    ST_REQ = 1'b0,
    ST_BUF = 1'b1
  } fetch_state_e;

  // A redirect only happens when the PC is allowed to move; 2'b11 falls back
  // to sequential and therefore never redirects.
  function automatic logic is_redirect(input logic pc_write, input logic [1:0] addr_sel);
    return pc_write & ((addr_sel == ADDR_JUMP) | (addr_sel == ADDR_BRANCH));
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_ifid_register.sv
// ----------------------------------------------------------------------------
// ifid_register
// IF/ID pipeline register holding the fetched instruction, its PC+4 and a
// valid flag.
// Ports:
//   Clk, Rst      clock, synchronous active-high reset (clears everything)
//   enable        1 = register loads this cycle, 0 = contents held
//   flush         with enable: load a NOP (instr=0, pc4=0, valid=0)
//   next_instr    instruction to load when not flushing
//   next_pc4      PC+4 of next_instr
//   instr, pc4, valid   registered outputs to decode
// ----------------------------------------------------------------------------
module ifid_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               enable,
  input  logic               flush,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [ADDR_W-1:0]  next_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4,
  output logic               valid
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      instr <= INSTR_W'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (enable) begin
      if (flush) begin
        instr <= INSTR_W'(NOP_INSTR);
        pc4   <= '0;
        valid <= 1'b0;
      end else begin
        instr <= next_instr;
        pc4   <= next_pc4;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
// Fetch stage of the 5-stage pipeline: PC register, next-PC select, request
// to a multi-cycle instruction memory (req/ready), one-entry hold buffer for a
// response that arrives while IF/ID is frozen, and the IF/ID register.
// Ports:
//   Clk, Rst              clock, synchronous active-high reset
//   PC_write, IF_write    hazard-unit enables for PC and IF/ID
//   addrSel               00 seq, 01 jump, 10 branch, 11 seq
//   jumpTarget            jump destination from decode
//   branchTarget          branch destination from execute
//   imem_req, imem_addr   fetch request and address (= PC)
//   imem_rdata, imem_ready  memory response
//   ifid_instr, ifid_pc4, ifid_valid   IF/ID register contents
//   fetch_stall           waiting on imem; pipeline must freeze
// ----------------------------------------------------------------------------
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               PC_write,
  input  logic               IF_write,
  input  logic [1:0]         addrSel,
  input  logic [ADDR_W-1:0]  jumpTarget,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               ifid_valid,
  output logic               fetch_stall
);

  fetch_state_e       state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next, pc4, target;
  logic [INSTR_W-1:0] hold_buf, ifid_data;
  logic               hold_load, ifid_flush, redirect;

  assign pc4       = pc + ADDR_W'(4);  // wraps modulo 2^ADDR_W
  assign redirect  = is_redirect(PC_write, addrSel);
  // Targets are word-aligned by clearing the low two bits.
  assign target    = ((addrSel == ADDR_JUMP) ? jumpTarget : branchTarget) & ~ADDR_W'(3);
  assign imem_addr = pc;

  // NOTE: hold_buf is a single data register, so it is cleared on reset along
  // with the control state; nothing relies on it until BUF is entered anyway.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      hold_buf <= INSTR_W'(NOP_INSTR);
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (hold_load) hold_buf <= imem_rdata;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    hold_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_data   = imem_rdata;
    imem_req    = 1'b0;
    fetch_stall = 1'b0;
    unique case (state)
      ST_REQ: begin
        // Suppressed while Rst is high so no request is issued in the reset cycle.
        imem_req = ~Rst;
        if (redirect) begin
          // Any same-cycle response belongs to the abandoned path.
          pc_next    = target;
          ifid_flush = 1'b1;
        end else if (imem_ready) begin
          if (IF_write) begin
            if (PC_write) pc_next = pc4;
          end else begin
            hold_load  = 1'b1;
            state_next = ST_BUF;
          end
        end else begin
          ifid_flush  = 1'b1;  // bubble into decode while memory is busy
          fetch_stall = 1'b1;
        end
      end
      ST_BUF: begin
        ifid_data = hold_buf;
        if (redirect) begin
          pc_next    = target;
          ifid_flush = 1'b1;
          state_next = ST_REQ;
        end else if (IF_write) begin
          if (PC_write) pc_next = pc4;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  // IF_write alone gates the IF/ID load: in REQ with a response and IF_write=0
  // the data goes to hold_buf instead, so no other case needs masking.
  ifid_register #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_ifid (
    .Clk       (Clk),
    .Rst       (Rst),
    .enable    (IF_write),
    .flush     (ifid_flush),
    .next_instr(ifid_data),
    .next_pc4  (pc4),
    .instr     (ifid_instr),
    .pc4       (ifid_pc4),
    .valid     (ifid_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. The memory model answers every
// address with addr + 0x100. Each table row drives inputs, then (before the
// next edge) compares the combinational outputs and the IF/ID contents left by
// the previous row's edge. A second instance with RESET_PC=0x1000 shares all
// inputs and is checked in the reset-mid-fetch sequence.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        PC_write, IF_write, imem_ready;
  logic [1:0]  addrSel;
  logic [31:0] jumpTarget, branchTarget;

  logic        imem_req, fetch_stall, ifid_valid;
  logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc4;

  logic        b_req, b_stall, b_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc4;

  always #5 Clk = ~Clk;

  assign imem_rdata = imem_addr + 32'h100;
  assign b_rdata    = b_addr + 32'h100;

  instruction_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Rst(Rst), .PC_write(PC_write), .IF_write(IF_write),
    .addrSel(addrSel), .jumpTarget(jumpTarget), .branchTarget(branchTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .fetch_stall(fetch_stall)
  );

  instruction_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h1000)) dut_b (
    .Clk(Clk), .Rst(Rst), .PC_write(PC_write), .IF_write(IF_write),
    .addrSel(addrSel), .jumpTarget(jumpTarget), .branchTarget(branchTarget),
    .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .imem_ready(imem_ready), .ifid_instr(b_instr), .ifid_pc4(b_pc4),
    .ifid_valid(b_valid), .fetch_stall(b_stall)
  );

  typedef struct {
    logic        pw, iw;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_instr, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic iw, input logic [1:0] sel,
                       input logic [31:0] tgt, input logic rdy);
    PC_write     = pw;
    IF_write     = iw;
    addrSel      = sel;
    jumpTarget   = tgt;
    branchTarget = tgt;
    imem_ready   = rdy;
  endtask

  task automatic add(input logic pw, input logic iw, input logic [1:0] sel,
                     input logic [31:0] tgt, input logic rdy, input logic e_req,
                     input logic [31:0] e_addr, input logic e_stall,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4,
                     input logic e_valid);
    vec_t v;
    v.pw = pw; v.iw = iw; v.sel = sel; v.tgt = tgt; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
    v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  initial begin
    // pw iw sel   tgt           rdy  req addr          stall instr         pc4           valid
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h0,        0,  32'h0,        32'h0,        0); // r0 first fetch
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h4,        0,  32'h100,      32'h4,        1); // r1
    add(1, 1, 2'b00, 32'h0,        0,  1, 32'h8,        1,  32'h104,      32'h8,        1); // r2 mem busy
    add(1, 1, 2'b00, 32'h0,        0,  1, 32'h8,        1,  32'h0,        32'h0,        0); // r3 mem busy
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h8,        0,  32'h0,        32'h0,        0); // r4 instr@8 arrives
    add(0, 0, 2'b00, 32'h0,        1,  1, 32'hC,        0,  32'h108,      32'hC,        1); // r5 load-use: to BUF
    add(0, 0, 2'b00, 32'h0,        1,  0, 32'hC,        0,  32'h108,      32'hC,        1); // r6 BUF frozen
    add(0, 0, 2'b00, 32'h0,        1,  0, 32'hC,        0,  32'h108,      32'hC,        1); // r7 BUF frozen
    add(1, 1, 2'b00, 32'h0,        1,  0, 32'hC,        0,  32'h108,      32'hC,        1); // r8 release buffer
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h10,       0,  32'h10C,      32'h10,       1); // r9
    add(1, 0, 2'b01, 32'h43,       1,  1, 32'h14,       0,  32'h110,      32'h14,       1); // r10 jump, resp dropped
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h40,       0,  32'h110,      32'h14,       1); // r11
    add(0, 0, 2'b00, 32'h0,        1,  1, 32'h44,       0,  32'h140,      32'h44,       1); // r12 to BUF
    add(1, 0, 2'b10, 32'h200,      1,  0, 32'h44,       0,  32'h140,      32'h44,       1); // r13 branch in BUF
    add(1, 1, 2'b00, 32'h0,        0,  1, 32'h200,      1,  32'h140,      32'h44,       1); // r14
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h200,      0,  32'h0,        32'h0,        0); // r15
    add(1, 1, 2'b01, 32'hFFFFFFFC, 1,  1, 32'h204,      0,  32'h300,      32'h204,      1); // r16 jump + flush
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'hFFFFFFFC, 0,  32'h0,        32'h0,        0); // r17
    add(1, 1, 2'b11, 32'h0,        1,  1, 32'h0,        0,  32'hFC,       32'h0,        1); // r18 PC wrapped; sel 11 = seq
    add(1, 1, 2'b11, 32'h0,        1,  1, 32'h4,        0,  32'h100,      32'h4,        1); // r19
    add(1, 1, 2'b01, 32'h80,       0,  1, 32'h8,        0,  32'h104,      32'h8,        1); // r20 redirect hides stall
    add(0, 1, 2'b01, 32'h300,      1,  1, 32'h80,       0,  32'h0,        32'h0,        0); // r21 no redirect w/o PC_write
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h80,       0,  32'h180,      32'h84,       1); // r22 refetch same PC
    add(1, 1, 2'b00, 32'h0,        1,  1, 32'h84,       0,  32'h180,      32'h84,       1); // r23

    Rst = 1'b1;
    drive(1, 1, 2'b00, 32'h0, 1);
    repeat (2) @(posedge Clk);
    #1;
    check("req_in_reset", {31'b0, imem_req}, 32'h0);
    check("addr_after_reset", imem_addr, 32'h0);
    check("valid_after_reset", {31'b0, ifid_valid}, 32'h0);
    Rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].pw, vecs[i].iw, vecs[i].sel, vecs[i].tgt, vecs[i].rdy);
      #1;
      check($sformatf("r%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      check($sformatf("r%0d_addr", i),  imem_addr,            vecs[i].e_addr);
      check($sformatf("r%0d_stall", i), {31'b0, fetch_stall}, {31'b0, vecs[i].e_stall});
      check($sformatf("r%0d_instr", i), ifid_instr,           vecs[i].e_instr);
      check($sformatf("r%0d_pc4", i),   ifid_pc4,             vecs[i].e_pc4);
      check($sformatf("r%0d_valid", i), {31'b0, ifid_valid},  {31'b0, vecs[i].e_valid});
      @(posedge Clk);
      #1;
    end

    // Reset while a request is pending at 0x20 (both instances jump there).
    drive(1, 1, 2'b01, 32'h20, 1);
    @(posedge Clk); #1;
    drive(1, 1, 2'b00, 32'h0, 0);
    #1;
    check("pend_b_addr", b_addr, 32'h20);
    check("pend_b_stall", {31'b0, b_stall}, 32'h1);
    @(posedge Clk); #1;
    check("pend_b_valid", {31'b0, b_valid}, 32'h0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("rst_b_req", {31'b0, b_req}, 32'h0);
    Rst = 1'b0;
    drive(1, 1, 2'b00, 32'h0, 1);
    #1;
    check("rst_b_addr", b_addr, 32'h1000);
    check("rst_b_req_after", {31'b0, b_req}, 32'h1);
    check("rst_b_valid", {31'b0, b_valid}, 32'h0);
    check("rst_b_instr", b_instr, 32'h0);
    check("rst_a_addr", imem_addr, 32'h0);
    @(posedge Clk); #1;
    check("rst_b_fetch_instr", b_instr, 32'h1100);
    check("rst_b_fetch_pc4", b_pc4, 32'h1004);
    check("rst_b_fetch_valid", {31'b0, b_valid}, 32'h1);
    check("rst_b_next_addr", b_addr, 32'h1004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
